// File: rtl/bitser_ctrl.sv
// Control sequencer for the bit-serial datapath: decodes the 3-bit opcode,
// owns the serial bit counter and multiply phase, and drives the datapath strobes.
module bitser_ctrl #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned CW          = $clog2(WIDTH),
    parameter int unsigned GPR_ALIGN_Y = 2,
    parameter int unsigned GPR_ALIGN_X = 1,
    parameter int unsigned ACC_ALIGN   = 3
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_en,
    input  logic [2:0]    i_instr,
    input  logic          i_start,
    output logic [CW-1:0] o_bit_sel,
    output logic          o_con_mux,
    output logic          o_con_muxalu,
    output logic          o_con_gpr_shift,
    output logic          o_con_gpr_write,
    output logic          o_con_acc_shift,
    output logic          o_con_acc_write,
    output logic          o_con_pcincr,
    output logic          o_busy
);

    typedef enum logic [2:0] {
        OP_NOP     = 3'b000,
        OP_STALL   = 3'b001,
        OP_MULY    = 3'b010,
        OP_MULX    = 3'b011,
        OP_ADD0    = 3'b100,
        OP_ADD1    = 3'b101,
        OP_WAITREL = 3'b110,
        OP_LOAD    = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        PH_COPY  = 2'd0,
        PH_ALIGN = 2'd1,
        PH_COMB  = 2'd2
    } ph_e;

    localparam logic [CW-1:0] CNT_LAST   = CW'(WIDTH - 1);
    localparam logic [CW-1:0] GPR_ALN_Y  = CW'(GPR_ALIGN_Y);
    localparam logic [CW-1:0] GPR_ALN_X  = CW'(GPR_ALIGN_X);
    localparam logic [CW-1:0] ACC_ALN    = CW'(ACC_ALIGN);

    logic [CW-1:0] cnt_q, cnt_d;
    ph_e           ph_q, ph_d;
    logic [2:0]    prev_q, prev_d;

    logic          busy_q;
    logic          abort;
    logic [CW-1:0] cnt_eff;
    ph_e           ph_eff;
    logic          is_mul;
    logic          counted;
    logic          last;

    // Raw decode, before enable/reset gating
    logic mux_r, muxalu_r, gpr_shift_r, gpr_write_r, acc_shift_r, acc_write_r, pcincr_r;

    // An opcode change mid-instruction restarts decoding from the first cycle
    always_comb begin
        busy_q  = (cnt_q != '0) || (ph_q != PH_COPY);
        abort   = i_en && busy_q && (i_instr != prev_q);
        cnt_eff = abort ? '0 : cnt_q;
        ph_eff  = abort ? PH_COPY : ph_q;
        is_mul  = (i_instr == OP_MULY) || (i_instr == OP_MULX);
        counted = is_mul || (i_instr == OP_ADD0) || (i_instr == OP_ADD1) || (i_instr == OP_LOAD);
        last    = (cnt_eff == CNT_LAST);
    end

    // Next-state: counter, phase and last-opcode register
    always_comb begin
        cnt_d  = cnt_q;
        ph_d   = ph_q;
        prev_d = prev_q;
        if (i_en) begin
            prev_d = i_instr;
            if (counted) begin
                cnt_d = last ? '0 : cnt_eff + CW'(1);
                ph_d  = is_mul ? ph_eff : PH_COPY;
                if (is_mul && last) begin
                    case (ph_eff)
                        PH_COPY:  ph_d = PH_ALIGN;
                        PH_ALIGN: ph_d = PH_COMB;
                        default:  ph_d = PH_COPY;
                    endcase
                end
            end else begin
                cnt_d = '0;
                ph_d  = PH_COPY;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q  <= '0;
            ph_q   <= PH_COPY;
            prev_q <= OP_STALL;
        end else begin
            cnt_q  <= cnt_d;
            ph_q   <= ph_d;
            prev_q <= prev_d;
        end
    end

    // Opcode/phase decode of the datapath controls
    always_comb begin
        mux_r       = 1'b0;
        muxalu_r    = 1'b0;
        gpr_shift_r = 1'b0;
        gpr_write_r = 1'b0;
        acc_shift_r = 1'b0;
        acc_write_r = 1'b0;
        pcincr_r    = 1'b0;
        case (i_instr)
            OP_NOP:   pcincr_r = i_start;
            OP_STALL: pcincr_r = 1'b1;
            OP_MULY, OP_MULX: begin
                case (ph_eff)
                    PH_COPY: begin
                        muxalu_r    = 1'b1;
                        gpr_shift_r = 1'b1;
                        gpr_write_r = 1'b1;
                        acc_shift_r = 1'b1;
                        acc_write_r = 1'b1;
                    end
                    PH_ALIGN: begin
                        gpr_shift_r = (i_instr == OP_MULY) ? (cnt_eff < GPR_ALN_Y)
                                                           : (cnt_eff < GPR_ALN_X);
                        acc_shift_r = (cnt_eff < ACC_ALN);
                    end
                    default: begin
                        gpr_shift_r = 1'b1;
                        gpr_write_r = 1'b1;
                        acc_shift_r = 1'b1;
                        acc_write_r = (i_instr == OP_MULX);
                        pcincr_r    = last;
                    end
                endcase
            end
            OP_ADD0, OP_ADD1: begin
                gpr_shift_r = 1'b1;
                gpr_write_r = 1'b1;
                acc_shift_r = 1'b1;
                pcincr_r    = last;
            end
            OP_WAITREL: pcincr_r = ~i_start;
            default: begin
                mux_r       = 1'b1;
                gpr_shift_r = 1'b1;
                gpr_write_r = 1'b1;
                pcincr_r    = last;
            end
        endcase
    end

    // Strobes need the enable; selects track state; everything is quiet in reset
    always_comb begin
        o_bit_sel       = i_rst_n ? cnt_eff : '0;
        o_busy          = i_rst_n & busy_q;
        o_con_mux       = i_rst_n & mux_r;
        o_con_muxalu    = i_rst_n & muxalu_r;
        o_con_gpr_shift = i_rst_n & i_en & gpr_shift_r;
        o_con_gpr_write = i_rst_n & i_en & gpr_write_r;
        o_con_acc_shift = i_rst_n & i_en & acc_shift_r;
        o_con_acc_write = i_rst_n & i_en & acc_write_r;
        o_con_pcincr    = i_rst_n & i_en & pcincr_r;
    end

endmodule
